// File: rtl/nvm_burst_read_ctrl_if.sv
// Host/array bundle for the NVM burst read sequencer.
// The host drives read_en, start_addr, num_words and abort. The controller drives
// the array-side strobes (nvm_addr, nvm_req, load, shift) and the status pulses
// (word_done, done, busy).
// The master modport is the host side. The slave modport is the controller side.
interface nvm_burst_read_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic              read_en;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] num_words;
    logic              abort;
    logic [ADDR_W-1:0] nvm_addr;
    logic              nvm_req;
    logic              load;
    logic              shift;
    logic              word_done;
    logic              done;
    logic              busy;

    modport master (
        output read_en, start_addr, num_words, abort,
        input  nvm_addr, nvm_req, load, shift, word_done, done, busy
    );

    modport slave (
        input  read_en, start_addr, num_words, abort,
        output nvm_addr, nvm_req, load, shift, word_done, done, busy
    );
endinterface

// File: rtl/nvm_burst_read_ctrl.sv
// Multi-word NVM read sequencer.
// For each word, the controller:
//   1. presents the word address,
//   2. holds nvm_req for WAIT_CYC cycles,
//   3. pulses load for one cycle,
//   4. then shifts DATA_W bits out.
// The next word follows immediately, with no gap. A normal completion ends with a
// one-cycle done pulse. Every output is a flop loaded from the next-state
// decode, so the outputs change only on the clock edge.
// Ports:
//   clk : rising-edge clock.
//   rst : synchronous active-high reset.
//   bus : slave side of nvm_burst_read_ctrl_if.
//         Inputs: read_en, start_addr, num_words, abort.
//         Outputs: nvm_addr, nvm_req, load, shift, word_done, done, busy.
module nvm_burst_read_ctrl #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 8,
    parameter int WAIT_CYC = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    nvm_burst_read_ctrl_if.slave bus
);
    // One counter serves both the access wait and the bit count, so it is sized for the larger of the two.
    localparam int CNT_MAX = (DATA_W > WAIT_CYC) ? DATA_W : WAIT_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] ACC_LAST   = CNT_W'(WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCESS = 3'd1,
        LOAD   = 3'd2,
        SHIFT  = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [ADDR_W-1:0] rem_q,   rem_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic              req_q,   req_d;
    logic              load_q,  load_d;
    logic              shift_q, shift_d;
    logic              wdone_q, wdone_d;
    logic              done_q,  done_d;
    logic              busy_q,  busy_d;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (bus.read_en && !bus.abort) begin
                    cnt_d = '0;
                    if (bus.num_words != '0) begin
                        state_d = ACCESS;
                        addr_d  = bus.start_addr;
                        rem_d   = bus.num_words;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q == ACC_LAST) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LOAD: begin
                state_d = SHIFT;
                cnt_d   = '0;
            end
            SHIFT: begin
                if (cnt_q == SHIFT_LAST) begin
                    cnt_d = '0;
                    if (rem_q == ADDR_W'(1)) begin
                        state_d = DONE;
                    end else begin
                        state_d = ACCESS;
                        rem_d   = rem_q - 1'b1;
                        // The address wraps silently modulo 2^ADDR_W.
                        addr_d  = addr_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Abort drops any active state straight to IDLE, so the cancelled word issues no done or word_done.
        if (state_q != IDLE && bus.abort) begin
            state_d = IDLE;
            cnt_d   = '0;
        end

        // The outputs are decoded from the next state and then registered, so they line up with that state.
        req_d   = (state_d == ACCESS);
        load_d  = (state_d == LOAD);
        shift_d = (state_d == SHIFT);
        wdone_d = (state_d == SHIFT) && (cnt_d == SHIFT_LAST);
        done_d  = (state_d == DONE);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            load_q  <= 1'b0;
            shift_q <= 1'b0;
            wdone_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            load_q  <= load_d;
            shift_q <= shift_d;
            wdone_q <= wdone_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.nvm_addr  = addr_q;
    assign bus.nvm_req   = req_q;
    assign bus.load      = load_q;
    assign bus.shift     = shift_q;
    assign bus.word_done = wdone_q;
    assign bus.done      = done_q;
    assign bus.busy      = busy_q;
endmodule
